// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   - default reset PC and bubble (NOP) instruction word
//   - fetch FSM state encoding (2 bits)
//   - small PC helper functions (word increment, word alignment)
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_START = 2'd0,   // first cycle after reset release, issues first request
        ST_WAIT  = 2'd1,   // exactly one request outstanding
        ST_HOLD  = 2'd2,   // skid buffer holds a response blocked by a stall
        ST_DROP  = 2'd3    // a stale response is still in flight and must be eaten
    } fetch_state_e;

    // Next sequential word address; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are always word aligned, whatever the low bits say.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Flush has priority over load; with neither the
// register holds (this is also how a stall is honoured).
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   load            capture load_instr / load_pc4 and mark valid
//   flush           replace contents with a bubble (NOP, pc4 = 0, invalid)
//   load_instr      instruction word to capture
//   load_pc4        PC+4 of that instruction
//   instr, id_pc4, id_valid   registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic [31:0] instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    // Select flush, load or hold for the next register contents.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = load_instr;
            pc4_d   = load_pc4;
            valid_d = 1'b1;
        end else begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end
    end

    // IF/ID storage with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign id_pc4   = pc4_q;
    assign id_valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the fetch PC,
// keeps at most one instruction-memory request outstanding, buffers one
// response when ID is stalled and drives the IF/ID register.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cu_wpcir                 stall from control unit (hold PC and IF/ID)
//   cu_branch, cu_jump       redirect requests resolved in ID this cycle
//   br_target, jmp_target    redirect targets (jump wins when both set)
//   imem_req, imem_addr      combinational one-cycle request pulse/address
//   imem_rvalid, imem_rdata  memory response strobe and word
//   if_instr                 word fetched this cycle, NOP when none
//   instr, id_pc4, id_valid  IF/ID register contents
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cu_wpcir,
    input  logic        cu_branch,
    input  logic        cu_jump,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;

    logic         redirect_s;
    logic [31:0]  target_s;
    logic [31:0]  pc_next_s;
    logic         req_s;
    logic [31:0]  addr_s;
    logic         load_s;
    logic [31:0]  load_instr_s;
    logic [31:0]  fetched_s;

    assign redirect_s = cu_branch | cu_jump;
    assign target_s   = align_word(cu_jump ? jmp_target : br_target);
    assign pc_next_s  = pc_plus4(fetch_pc_q);

    // Fetch FSM: next state, fetch PC, skid buffer, request and IF/ID load.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        hold_instr_d = hold_instr_q;
        req_s        = 1'b0;
        addr_s       = 32'h0000_0000;
        load_s       = 1'b0;
        load_instr_s = NOP_INSTR;
        fetched_s    = NOP_INSTR;
        case (state_q)
            ST_START: begin
                // Any response seen here belongs to a pre-reset request.
                req_s   = 1'b1;
                state_d = ST_WAIT;
                if (redirect_s) begin
                    fetch_pc_d = target_s;
                    addr_s     = target_s;
                end else begin
                    addr_s = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    fetched_s = imem_rdata;
                    if (redirect_s) begin
                        // Response is on the wrong path: drop it, refetch at target.
                        fetch_pc_d = target_s;
                        req_s      = 1'b1;
                        addr_s     = target_s;
                    end else if (cu_wpcir) begin
                        hold_instr_d = imem_rdata;
                        state_d      = ST_HOLD;
                    end else begin
                        load_s       = 1'b1;
                        load_instr_s = imem_rdata;
                        fetch_pc_d   = pc_next_s;
                        req_s        = 1'b1;
                        addr_s       = pc_next_s;
                    end
                end else if (redirect_s) begin
                    // The outstanding response is stale; remember where to go.
                    fetch_pc_d = target_s;
                    state_d    = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                fetched_s = hold_instr_q;
                if (redirect_s) begin
                    fetch_pc_d = target_s;
                    req_s      = 1'b1;
                    addr_s     = target_s;
                    state_d    = ST_WAIT;
                end else if (cu_wpcir) begin
                    state_d = ST_HOLD;
                end else begin
                    load_s       = 1'b1;
                    load_instr_s = hold_instr_q;
                    fetch_pc_d   = pc_next_s;
                    req_s        = 1'b1;
                    addr_s       = pc_next_s;
                    state_d      = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    // Stale word consumed; a same-cycle redirect still wins.
                    req_s   = 1'b1;
                    state_d = ST_WAIT;
                    if (redirect_s) begin
                        fetch_pc_d = target_s;
                        addr_s     = target_s;
                    end else begin
                        addr_s = fetch_pc_q;
                    end
                end else if (redirect_s) begin
                    fetch_pc_d = target_s;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d    = ST_START;
                fetch_pc_d = RESET_PC;
            end
        endcase
    end

    // FSM state, fetch PC and skid buffer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_START;
            fetch_pc_q   <= RESET_PC;
            hold_instr_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Requests are suppressed while reset is held so the bus idles at zero.
    assign imem_req  = req_s & rst;
    assign imem_addr = (req_s & rst) ? addr_s : 32'h0000_0000;
    assign if_instr  = redirect_s ? NOP_INSTR : fetched_s;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .flush      (redirect_s),
        .load_instr (load_instr_s),
        .load_pc4   (pc_next_s),
        .instr      (instr),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Scoreboard bench. The driver models the instruction stream the pipeline
// should deliver (sequential words from the current path start, restarted
// at every redirect or reset) and pushes expected IF/ID entries into a queue.
// A separate monitor pops an entry whenever a new instruction appears in
// IF/ID and also checks flush, stall-hold and reset behaviour.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cu_wpcir = 1'b0;
    logic        cu_branch = 1'b0;
    logic        cu_jump = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] jmp_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_instr;
    logic [31:0] instr;
    logic [31:0] id_pc4;
    logic        id_valid;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .cu_wpcir    (cu_wpcir),
        .cu_branch   (cu_branch),
        .cu_jump     (cu_jump),
        .br_target   (br_target),
        .jmp_target  (jmp_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_instr    (if_instr),
        .instr       (instr),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc4;
    } exp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_loaded = 0;
    exp_t        exp_q[$];
    logic [31:0] gen_pc = 32'h0;
    logic [31:0] mem_ovr [bit [31:0]];
    bit          mem_ident = 1'b1;

    bit          rsp_busy = 1'b0;
    int          rsp_cnt  = 0;
    logic [31:0] rsp_addr = 32'h0;
    int          lat_cfg  = 1;
    bit          force_rv = 1'b0;
    logic [31:0] force_data = 32'h0;

    bit          cyc_rst = 1'b1;
    bit          cyc_redirect = 1'b0;
    bit          cyc_stall = 1'b0;

    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_if_instr;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        else if (mem_ident) return a;
        else return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock cycle: drive inputs at negedge, answer memory, sample at +1.
    task automatic cycle(input bit r, input bit st, input bit br, input bit jp,
                         input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] tgt;
        @(negedge clk);
        rst = r; cu_wpcir = st; cu_branch = br; cu_jump = jp;
        br_target = bt; jmp_target = jt;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        if (!r) begin
            rsp_busy = 1'b0;
        end else if (force_rv) begin
            imem_rvalid = 1'b1; imem_rdata = force_data; force_rv = 1'b0;
        end else if (rsp_busy) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imem_rvalid = 1'b1; imem_rdata = mem_rd(rsp_addr); rsp_busy = 1'b0;
            end
        end
        cyc_rst      = !r;
        cyc_redirect = r && (br || jp);
        cyc_stall    = r && st && !(br || jp);
        tgt = jp ? jt : bt;
        tgt[1:0] = 2'b00;
        if (!r) begin
            exp_q.delete(); gen_pc = 32'h0000_0000;
        end else if (br || jp) begin
            exp_q.delete(); gen_pc = tgt;
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back('{mem_rd(gen_pc), gen_pc + 32'd4});
            gen_pc = gen_pc + 32'd4;
        end
        #1;
        s_req = imem_req; s_addr = imem_addr; s_if_instr = if_instr;
        if (cyc_redirect) check("if_instr_nop_on_redirect", if_instr, NOP);
        if (!r) begin
            check("req_in_reset", {31'd0, imem_req}, 32'd0);
            check("addr_in_reset", imem_addr, 32'd0);
        end
        if (imem_req) begin
            check("single_outstanding", {31'd0, rsp_busy}, 32'd0);
            check("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
            rsp_busy = 1'b1;
            rsp_cnt  = (lat_cfg == 0) ? int'($urandom_range(3, 1)) : lat_cfg;
            rsp_addr = imem_addr;
        end
    endtask

    task automatic chk_id(input string name, input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        check({name, "_instr"}, instr, ei);
        check({name, "_pc4"}, id_pc4, ep);
        check({name, "_valid"}, {31'd0, id_valid}, {31'd0, ev});
    endtask

    // Monitor: compares IF/ID after every rising edge against the scoreboard.
    initial begin
        logic [31:0] l_instr;
        logic [31:0] l_pc4;
        logic        l_valid;
        exp_t        e;
        l_instr = 32'h0; l_pc4 = 32'h0; l_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_rst) begin
                check("reset_instr", instr, NOP);
                check("reset_pc4", id_pc4, 32'd0);
                check("reset_valid", {31'd0, id_valid}, 32'd0);
            end else if (cyc_redirect) begin
                check("flush_instr", instr, NOP);
                check("flush_pc4", id_pc4, 32'd0);
                check("flush_valid", {31'd0, id_valid}, 32'd0);
            end else if (cyc_stall) begin
                check("stall_hold_instr", instr, l_instr);
                check("stall_hold_pc4", id_pc4, l_pc4);
                check("stall_hold_valid", {31'd0, id_valid}, {31'd0, l_valid});
            end else if (id_valid && (!l_valid || id_pc4 !== l_pc4)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_empty: got instr %h pc4 %h, expected none", instr, id_pc4);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", instr, e.word);
                    check("sb_pc4", id_pc4, e.pc4);
                    n_loaded++;
                end
            end
            l_instr = instr; l_pc4 = id_pc4; l_valid = id_valid;
        end
    end

    initial begin
        mem_ovr[32'h0000_000C] = 32'h8C22_0004;
        mem_ident = 1'b1;
        lat_cfg = 1;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // Sequential fetch with a 1-cycle memory.
        cycle(1, 0, 0, 0, 0, 0);
        check("A_req", {31'd0, s_req}, 32'd1); check("A_addr", s_addr, 32'h0);
        cycle(1, 0, 0, 0, 0, 0);
        check("B_req", {31'd0, s_req}, 32'd1); check("B_addr", s_addr, 32'h4);
        cycle(1, 0, 0, 0, 0, 0);
        check("C_addr", s_addr, 32'h8); check("C_if_instr", s_if_instr, 32'h4);
        chk_id("C", 32'h0, 32'h4, 1'b1);
        cycle(1, 0, 0, 0, 0, 0);
        check("D_addr", s_addr, 32'hC); chk_id("D", 32'h4, 32'h8, 1'b1);
        // Stall for three cycles while 0x8C22_0004 arrives.
        cycle(1, 1, 0, 0, 0, 0);
        check("E_req", {31'd0, s_req}, 32'd0); check("E_if_instr", s_if_instr, 32'h8C22_0004);
        chk_id("E", 32'h8, 32'hC, 1'b1);
        cycle(1, 1, 0, 0, 0, 0);
        check("F_req", {31'd0, s_req}, 32'd0);
        cycle(1, 1, 0, 0, 0, 0);
        check("G_req", {31'd0, s_req}, 32'd0); chk_id("G", 32'h8, 32'hC, 1'b1);
        cycle(1, 0, 0, 0, 0, 0);
        check("H_req", {31'd0, s_req}, 32'd1); check("H_addr", s_addr, 32'h10);
        // Taken branch on a response cycle.
        cycle(1, 0, 1, 0, 32'h40, 0);
        check("I_addr", s_addr, 32'h40); chk_id("I", 32'h8C22_0004, 32'h10, 1'b1);
        lat_cfg = 3;
        cycle(1, 0, 0, 0, 0, 0);
        chk_id("J", NOP, 32'h0, 1'b0);
        // Jump with a slow memory: stale response must be dropped.
        cycle(1, 0, 0, 1, 0, 32'h103);
        check("K_req", {31'd0, s_req}, 32'd0); chk_id("K", 32'h40, 32'h44, 1'b1);
        cycle(1, 0, 0, 0, 0, 0);
        check("L_req", {31'd0, s_req}, 32'd0);
        lat_cfg = 1;
        cycle(1, 0, 0, 0, 0, 0);
        check("M_req", {31'd0, s_req}, 32'd1); check("M_addr", s_addr, 32'h100);
        check("M_if_instr", s_if_instr, NOP);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk_id("O", 32'h100, 32'h104, 1'b1);
        // Stall and branch together: redirect wins.
        cycle(1, 1, 1, 0, 32'h200, 0);
        check("P_req", {31'd0, s_req}, 32'd1); check("P_addr", s_addr, 32'h200);
        cycle(1, 0, 0, 0, 0, 0);
        chk_id("Q", NOP, 32'h0, 1'b0);
        lat_cfg = 2;
        cycle(1, 0, 0, 0, 0, 0);
        chk_id("R", 32'h200, 32'h204, 1'b1);
        // Reset during WAIT, stale response in the START cycle.
        cycle(0, 0, 0, 0, 0, 0);
        lat_cfg = 1; force_rv = 1'b1; force_data = 32'hDEAD_BEEF;
        cycle(1, 0, 0, 0, 0, 0);
        check("T_req", {31'd0, s_req}, 32'd1); check("T_addr", s_addr, 32'h0);
        check("T_if_instr", s_if_instr, NOP); chk_id("T", NOP, 32'h0, 1'b0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk_id("V", 32'h0, 32'h4, 1'b1);
        // Randomised traffic with variable latency, stalls and redirects.
        mem_ident = 1'b0; lat_cfg = 0;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cycle(1, $urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0,
                  $urandom_range(12, 0) == 0,
                  32'($urandom_range(32'h3FF, 0)), 32'($urandom_range(32'h3FF, 0)));
        end
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0);
        check("loaded_progress", {31'd0, n_loaded > 100}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
